mem_scan_viewer: RTL
====================

Name: mem_scan_viewer

Overview:
- Parametrised dual-port memory with an auto-scanning read pointer.
- Generalises the board-level 32x4 RAM viewer into a reusable block with configurable width, depth and scan rate.
- Adds run/hold/single-step modes, write-first collision bypass and address-aligned read output.
- Sits between switch/key input logic and the seven-segment display drivers; display logic consumes scan_addr/scan_data directly.

Parameters:
- DATA_W, 4: data word width in bits.
- DEPTH, 32: number of words; need not be a power of two.
- ADDR_W, 5: address width; must satisfy 2**ADDR_W >= DEPTH.
- TICK_MAX, 33554431: scan advances once every TICK_MAX+1 clk cycles in RUN mode.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- wr_en  in  1  write strobe, sampled each clk
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- mode  in  2  00 RUN, 01 HOLD, 10 STEP, 11 reserved (treated as HOLD)
- step_in  in  1  level input; a rising edge advances the pointer in STEP mode
- scan_addr  out  ADDR_W  address whose contents are on scan_data
- scan_data  out  DATA_W  memory contents at scan_addr
- scan_valid  out  1  scan_addr/scan_data pair is valid
- wr_hit  out  1  registered; 1 when last cycle's write targeted the scanned address

Behaviour:
- Clocking and reset:
  - Reset is synchronous, active-high, on clock clk.
  - During reset: rd_ptr=0, tick counter=0, step edge register=0, scan_addr=0, scan_data=0, scan_valid=0, wr_hit=0.
  - Memory contents are not reset unless MEM_CLEAR_EN is defined.
- Write port:
  - Synchronous write on clk when wr_en=1 and wr_addr<DEPTH.
  - wr_addr>=DEPTH: write dropped, no side effects.
- Tick generator:
  - Counts 0..TICK_MAX and free-runs in all modes.
  - tick=1 for one cycle when count==TICK_MAX; count then wraps to 0.
- Pointer advance:
  - RUN: rd_ptr advances on tick.
  - HOLD and reserved mode: rd_ptr never advances.
  - STEP: rd_ptr advances on the cycle after step_in goes 0->1 (edge detect is internal); tick is ignored.
- Advance rule: rd_ptr increments, and wraps from DEPTH-1 to 0.
- Mode change takes effect the next cycle. It does not reset rd_ptr or the tick counter.
- Read path:
  - Synchronous read every cycle at rd_ptr.
  - On the following edge, scan_addr<=rd_ptr and scan_data<=mem[rd_ptr], giving 1-cycle latency with address and data always aligned.
- Collision:
  - Condition: wr_en=1, wr_addr==rd_ptr, in the same cycle.
  - Next cycle: scan_data=wr_data (write-first) and wr_hit=1.
  - Otherwise wr_hit=0.
- scan_valid goes to 1 on the first clk after reset deasserts and stays 1.
- Reset asserted mid-scan returns all state to the reset values above on that edge.

Optional Feature:
- Macro: MEM_CLEAR_EN.
- When defined:
  - Reset enters state CLEAR. Each cycle writes 0 to clr_ptr, for DEPTH cycles covering addresses 0..DEPTH-1.
  - External writes are ignored during CLEAR, scan_valid=0 and rd_ptr is held at 0.
  - After address DEPTH-1, the block moves to SCAN and scan_valid rises one cycle later.
  - Reset during CLEAR restarts the clear from address 0.
- When undefined: no CLEAR state; memory is uninitialised; scan_valid rises 1 cycle after reset.

Decomposition:
- Package mem_scan_pkg:
  - typedef enum scan_mode_t {MODE_RUN, MODE_HOLD, MODE_STEP, MODE_RSVD}
  - typedef enum ctrl_state_t {ST_CLEAR, ST_SCAN}
- Sub-module scan_tick_gen (parameter TICK_MAX; ports clk, reset, tick) holds the tick divider. The memory array, pointer and bypass stay in the top module.

Test Plan:
- TICK_MAX=3, DEPTH=32, RUN after reset -> scan_addr sequence 0,1,2,... advancing every 4 cycles; 31 wraps to 0.
- DEPTH=10, ADDR_W=4, RUN -> scan_addr 9 followed by 0; never 10..15.
- Write 8 to addr 2 while scanning, then observe at scan_addr=2 -> scan_data=8. Write to addr 20 with DEPTH=10 -> no memory change.
- HOLD at scan_addr=5 for 20 cycles -> scan_addr stays 5. STEP with 3 pulses on step_in -> 6,7,8. Holding step_in high -> exactly one advance.
- wr_en=1, wr_addr=rd_ptr=4, wr_data=0xA -> next cycle scan_data=0xA, wr_hit=1. Following cycle wr_hit=0.
- MEM_CLEAR_EN defined: pre-write 0xF everywhere, then reset -> scan_valid low for DEPTH cycles, then all addresses read 0. A write during CLEAR is ignored.

Source files
------------

// File: rtl/mem_scan_pkg.sv
// Shared types for mem_scan_viewer: scan modes and controller states.
package mem_scan_pkg;

    typedef enum logic [1:0] {
        MODE_RUN  = 2'b00,
        MODE_HOLD = 2'b01,
        MODE_STEP = 2'b10,
        MODE_RSVD = 2'b11
    } scan_mode_t;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_SCAN  = 1'b1
    } ctrl_state_t;

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running divider: tick pulses for one cycle every TICK_MAX+1 clocks.
module scan_tick_gen #(
    parameter int unsigned TICK_MAX = 33554431
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CNT_W = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_MAX);

    logic [CNT_W-1:0] count;

    assign tick = (count == CNT_MAX);

    // NOTE: state is updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_scan_viewer.sv
// Dual-port memory viewer with an auto-scanning read pointer (RUN/HOLD/STEP).
// Define MEM_CLEAR_EN to zero the memory after reset before scanning starts.
module mem_scan_viewer
    import mem_scan_pkg::*;
#(
    parameter int          DATA_W   = 4,
    parameter int          DEPTH    = 32,
    parameter int          ADDR_W   = 5,
    parameter int unsigned TICK_MAX = 33554431
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [1:0]        mode,
    input  logic              step_in,
    output logic [ADDR_W-1:0] scan_addr,
    output logic [DATA_W-1:0] scan_data,
    output logic              scan_valid,
    output logic              wr_hit
);

    localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] rd_ptr;
    logic              step_q;
    logic              step_rise;
    logic              tick;
    logic              advance;
    logic              clearing;
    logic [ADDR_W-1:0] clr_addr;
    logic              ext_we;
    logic              collision;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    scan_tick_gen #(.TICK_MAX(TICK_MAX)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

`ifdef MEM_CLEAR_EN
    ctrl_state_t       state;
    ctrl_state_t       state_next;
    logic [ADDR_W-1:0] clr_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_CLEAR;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (state == ST_CLEAR && clr_ptr == LAST_ADDR) begin
            state_next = ST_SCAN;
        end
    end

    always_comb begin
        clearing = (state == ST_CLEAR);
    end

    // Reset during CLEAR restarts the sweep from address 0.
    always_ff @(posedge clk) begin
        if (reset || !clearing) begin
            clr_ptr <= '0;
        end else if (clr_ptr != LAST_ADDR) begin
            clr_ptr <= clr_ptr + ADDR_W'(1);
        end
    end

    assign clr_addr = clr_ptr;
`else
    assign clearing = 1'b0;
    assign clr_addr = '0;
`endif

    assign step_rise = step_in & ~step_q;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        advance = 1'b0;
        case (scan_mode_t'(mode))
            MODE_RUN:  advance = tick;
            MODE_STEP: advance = step_rise;
            default:   advance = 1'b0;
        endcase
        if (clearing) begin
            advance = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            step_q <= 1'b0;
        end else begin
            step_q <= step_in;
            if (clearing) begin
                rd_ptr <= '0;
            end else if (advance) begin
                rd_ptr <= (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + ADDR_W'(1);
            end
        end
    end

    // Out-of-range writes are dropped; the clear sweep owns the port while active.
    assign ext_we    = wr_en && ({1'b0, wr_addr} < DEPTH_L) && !clearing;
    assign collision = ext_we && (wr_addr == rd_ptr);
    assign mem_we    = ext_we || clearing;
    assign mem_waddr = clearing ? clr_addr : wr_addr;
    assign mem_wdata = clearing ? '0 : wr_data;

    // NOTE: the array has no reset branch so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Write-first bypass keeps scan_data consistent with the write just made.
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_addr  <= '0;
            scan_data  <= '0;
            scan_valid <= 1'b0;
            wr_hit     <= 1'b0;
        end else begin
            scan_addr  <= rd_ptr;
            scan_data  <= collision ? wr_data : mem[rd_ptr];
            scan_valid <= !clearing;
            wr_hit     <= collision;
        end
    end

endmodule
